// File: rtl/tpu_stream_loader_if.sv
// Host-side bundle of the stream loader: command/status, load and unload
// streams, and the external ports of BRAM A and BRAM B.
interface tpu_stream_loader_if #(
    parameter int DWIDTH       = 8,
    parameter int MAT_MUL_SIZE = 4,
    parameter int AWIDTH       = 10,
    parameter int MASK_WIDTH   = 4
);
    localparam int W = MAT_MUL_SIZE * DWIDTH;

    logic              start;
    logic              dir;
    logic              sel;
    logic [AWIDTH-1:0] base_addr;
    logic [AWIDTH-1:0] num_words;
    logic              busy;
    logic              done;

    logic              s_valid;
    logic              s_ready;
    logic [W-1:0]      s_data;
    logic              m_valid;
    logic              m_ready;
    logic [W-1:0]      m_data;

    logic [AWIDTH-1:0]     bram_addr_a_ext;
    logic [W-1:0]          bram_wdata_a_ext;
    logic [MASK_WIDTH-1:0] bram_we_a_ext;
    logic [W-1:0]          bram_rdata_a_ext;
    logic [AWIDTH-1:0]     bram_addr_b_ext;
    logic [W-1:0]          bram_wdata_b_ext;
    logic [MASK_WIDTH-1:0] bram_we_b_ext;
    logic [W-1:0]          bram_rdata_b_ext;

    modport master (
        input  start, dir, sel, base_addr, num_words,
        input  s_valid, s_data, m_ready,
        input  bram_rdata_a_ext, bram_rdata_b_ext,
        output busy, done, s_ready, m_valid, m_data,
        output bram_addr_a_ext, bram_wdata_a_ext, bram_we_a_ext,
        output bram_addr_b_ext, bram_wdata_b_ext, bram_we_b_ext
    );

    modport slave (
        output start, dir, sel, base_addr, num_words,
        output s_valid, s_data, m_ready,
        output bram_rdata_a_ext, bram_rdata_b_ext,
        input  busy, done, s_ready, m_valid, m_data,
        input  bram_addr_a_ext, bram_wdata_a_ext, bram_we_a_ext,
        input  bram_addr_b_ext, bram_wdata_b_ext, bram_we_b_ext
    );
endinterface

// File: rtl/tpu_stream_loader.sv
// Stream-to-BRAM loader/unloader: writes a valid/ready word stream into
// consecutive BRAM rows, or reads consecutive rows back out as a stream.
module tpu_stream_loader #(
    parameter int DWIDTH       = 8,
    parameter int MAT_MUL_SIZE = 4,
    parameter int AWIDTH       = 10,
    parameter int MASK_WIDTH   = 4,
    parameter int ADDR_STRIDE  = 4
) (
    input logic                clk,
    input logic                reset,
    tpu_stream_loader_if.master bus
);
    localparam int W          = MAT_MUL_SIZE * DWIDTH;
    localparam int FIFO_DEPTH = 4;

    typedef enum logic [1:0] {IDLE, LOAD, UNLOAD, FIN} state_t;

    state_t            state_q, state_d;
    logic              sel_q, sel_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              s_ready_q, s_ready_d;
    logic [AWIDTH-1:0] cur_q, cur_d;
    logic [AWIDTH-1:0] cnt_q, cnt_d;
    logic [AWIDTH-1:0] iss_q, iss_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [W-1:0]      wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              rd_req_p0_q, rd_req_p0_d;
    logic              rd_req_p1_q, rd_req_p1_d;
    logic [1:0]        wr_ptr_q, wr_ptr_d;
    logic [1:0]        rd_ptr_q, rd_ptr_d;
    logic [2:0]        fcnt_q, fcnt_d;
    logic [W-1:0]      fifo_mem [FIFO_DEPTH];

    logic              s_hs, push, pop, room;
    logic [W-1:0]      rdata_sel;
    logic [AWIDTH-1:0] stride;

    assign stride    = AWIDTH'(ADDR_STRIDE);
    assign rdata_sel = sel_q ? bus.bram_rdata_b_ext : bus.bram_rdata_a_ext;
    assign s_hs      = bus.s_valid && s_ready_q;
    assign push      = rd_req_p1_q;
    assign pop       = (fcnt_q != 3'd0) && bus.m_ready;
    // Reads in flight already own a FIFO slot, so occupancy can never pass 4.
    assign room      = ({1'b0, fcnt_q} + 4'(rd_req_p0_q) + 4'(rd_req_p1_q)) < 4'(FIFO_DEPTH);

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        s_ready_d   = s_ready_q;
        cur_d       = cur_q;
        cnt_d       = cnt_q;
        iss_d       = iss_q;
        addr_d      = addr_q;
        wdata_d     = '0;
        we_d        = 1'b0;
        rd_req_p0_d = 1'b0;
        rd_req_p1_d = rd_req_p0_q;
        wr_ptr_d    = wr_ptr_q + 2'(push);
        rd_ptr_d    = rd_ptr_q + 2'(pop);
        fcnt_d      = fcnt_q + 3'(push) - 3'(pop);
        unique case (state_q)
            IDLE: if (bus.start) begin
                sel_d = bus.sel;
                cur_d = bus.base_addr;
                cnt_d = bus.num_words;
                if (bus.num_words == '0) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                end else if (!bus.dir) begin
                    state_d   = LOAD;
                    busy_d    = 1'b1;
                    s_ready_d = 1'b1;
                end else begin
                    // The first read goes out together with the command accept.
                    state_d     = UNLOAD;
                    busy_d      = 1'b1;
                    addr_d      = bus.base_addr;
                    rd_req_p0_d = 1'b1;
                    cur_d       = bus.base_addr + stride;
                    iss_d       = bus.num_words - AWIDTH'(1);
                end
            end
            LOAD: begin
                if (s_hs) begin
                    addr_d  = cur_q;
                    wdata_d = bus.s_data;
                    we_d    = 1'b1;
                    cur_d   = cur_q + stride;
                    cnt_d   = cnt_q - AWIDTH'(1);
                    if (cnt_q == AWIDTH'(1)) s_ready_d = 1'b0;
                end else if (!s_ready_q) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                end
            end
            UNLOAD: begin
                if ((iss_q != '0) && room) begin
                    addr_d      = cur_q;
                    rd_req_p0_d = 1'b1;
                    cur_d       = cur_q + stride;
                    iss_d       = iss_q - AWIDTH'(1);
                end
                if (pop) begin
                    cnt_d = cnt_q - AWIDTH'(1);
                    if (cnt_q == AWIDTH'(1)) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                    end
                end
            end
            FIN: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sel_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            s_ready_q   <= 1'b0;
            cur_q       <= '0;
            cnt_q       <= '0;
            iss_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            rd_req_p0_q <= 1'b0;
            rd_req_p1_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            s_ready_q   <= s_ready_d;
            cur_q       <= cur_d;
            cnt_q       <= cnt_d;
            iss_q       <= iss_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            rd_req_p0_q <= rd_req_p0_d;
            rd_req_p1_q <= rd_req_p1_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fcnt_q      <= fcnt_d;
        end
    end

    // Read data arrives one cycle after its address; capture it here.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= rdata_sel;
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.s_ready = s_ready_q;
    assign bus.m_valid = (fcnt_q != 3'd0);
    assign bus.m_data  = (fcnt_q != 3'd0) ? fifo_mem[rd_ptr_q] : '0;

    assign bus.bram_addr_a_ext  = sel_q ? '0 : addr_q;
    assign bus.bram_wdata_a_ext = sel_q ? '0 : wdata_q;
    assign bus.bram_we_a_ext    = sel_q ? '0 : {MASK_WIDTH{we_q}};
    assign bus.bram_addr_b_ext  = sel_q ? addr_q : '0;
    assign bus.bram_wdata_b_ext = sel_q ? wdata_q : '0;
    assign bus.bram_we_b_ext    = sel_q ? {MASK_WIDTH{we_q}} : '0;
endmodule

// File: tb/tb_tpu_stream_loader.sv
// Self-checking bench for tpu_stream_loader: BRAM models plus a reference
// memory image that predicts every write address/data and every unloaded word.
module tb_tpu_stream_loader;
    localparam int DW = 8, MMS = 4, AW = 10, MW = 4, STRIDE = 4;
    localparam int W = DW * MMS;
    localparam int DEPTH = 1 << AW;

    typedef struct {
        bit d; bit s; int base; int num; int lat; int fa; int la;
    } vec_t;

    typedef struct {
        logic [AW-1:0] addr; logic [W-1:0] data; int cyc;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;

    bit [W-1:0] mem_a [DEPTH];
    bit [W-1:0] mem_b [DEPTH];
    bit [W-1:0] ref_a [DEPTH];
    bit [W-1:0] ref_b [DEPTH];
    logic [W-1:0] fixed_q [$];

    tpu_stream_loader_if #(.DWIDTH(DW), .MAT_MUL_SIZE(MMS), .AWIDTH(AW), .MASK_WIDTH(MW)) bus ();

    tpu_stream_loader #(
        .DWIDTH(DW), .MAT_MUL_SIZE(MMS), .AWIDTH(AW), .MASK_WIDTH(MW), .ADDR_STRIDE(STRIDE)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Byte-masked BRAMs with one cycle registered read latency.
    always @(posedge clk) begin
        for (int b = 0; b < MW; b++) begin
            if (bus.bram_we_a_ext[b]) mem_a[bus.bram_addr_a_ext][8*b +: 8] <= bus.bram_wdata_a_ext[8*b +: 8];
            if (bus.bram_we_b_ext[b]) mem_b[bus.bram_addr_b_ext][8*b +: 8] <= bus.bram_wdata_b_ext[8*b +: 8];
        end
        bus.bram_rdata_a_ext <= mem_a[bus.bram_addr_a_ext];
        bus.bram_rdata_b_ext <= mem_b[bus.bram_addr_b_ext];
    end

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    function automatic logic [AW-1:0] row(int base, int i);
        return AW'((base + i * STRIDE) % DEPTH);
    endfunction

    function automatic logic [W-1:0] next_word();
        if (fixed_q.size() != 0) return fixed_q.pop_front();
        return W'($urandom);
    endfunction

    function automatic bit drv(int mode, int t);
        if (mode == 0) return 1'b1;
        if (mode == 2) return ((t - 1) % 3) == 0;
        return 1'($urandom);
    endfunction

    function automatic int mem_diff(bit port_b);
        int n = 0;
        for (int i = 0; i < DEPTH; i++)
            if (port_b ? (mem_b[i] != ref_b[i]) : (mem_a[i] != ref_a[i])) n++;
        return n;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic outputs_zero(string tag);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_s_ready"}, bus.s_ready, 0);
        chk({tag, "_m_valid"}, bus.m_valid, 0);
        chk({tag, "_m_data"}, bus.m_data, 0);
        chk({tag, "_addr_a"}, bus.bram_addr_a_ext, 0);
        chk({tag, "_wdata_a"}, bus.bram_wdata_a_ext, 0);
        chk({tag, "_we_a"}, bus.bram_we_a_ext, 0);
        chk({tag, "_addr_b"}, bus.bram_addr_b_ext, 0);
        chk({tag, "_wdata_b"}, bus.bram_wdata_b_ext, 0);
        chk({tag, "_we_b"}, bus.bram_we_b_ext, 0);
    endtask

    // Runs one command from its start strobe (cycle 0) to two cycles past done.
    task automatic run_cmd(input bit d, input bit s, input int base, input int num, input int mode,
                           input bit restart, input int exp_lat, output int first_wa, output int last_wa);
        wr_t wq [$];
        wr_t w;
        logic [W-1:0] exp_q [$];
        logic [W-1:0] held, cur_data, exp_w;
        logic [AW-1:0] sa, oa;
        logic [W-1:0] sw, ow;
        logic [MW-1:0] swe, owe;
        bit stalled = 0;
        int sent = 0, popped = 0, writes = 0, dones = 0, done_at = -1, t;
        int bad_busy = 0, bad_side = 0;
        first_wa = -1;
        last_wa = -1;
        if (d) for (int i = 0; i < num; i++) exp_q.push_back(s ? ref_b[row(base, i)] : ref_a[row(base, i)]);
        cur_data = next_word();
        bus.start = 1'b1; bus.dir = d; bus.sel = s;
        bus.base_addr = AW'(base); bus.num_words = AW'(num);
        bus.s_valid = 1'b0; bus.m_ready = 1'b0;
        step();
        t = 1;
        bus.start = 1'b0;
        bus.dir = 1'($urandom); bus.sel = 1'($urandom);
        bus.base_addr = AW'($urandom); bus.num_words = AW'($urandom);
        while (t < 400) begin
            if (restart && t == 2) begin
                bus.start = 1'b1; bus.dir = ~d; bus.sel = ~s;
                bus.base_addr = AW'(base + 64); bus.num_words = AW'(5);
            end else begin
                bus.start = 1'b0;
            end
            bus.s_valid = !d && (sent < num) && drv(mode, t);
            bus.s_data = cur_data;
            bus.m_ready = d ? drv(mode, t) : 1'($urandom);
            #1;
            sa  = s ? bus.bram_addr_b_ext  : bus.bram_addr_a_ext;
            sw  = s ? bus.bram_wdata_b_ext : bus.bram_wdata_a_ext;
            swe = s ? bus.bram_we_b_ext    : bus.bram_we_a_ext;
            oa  = s ? bus.bram_addr_a_ext  : bus.bram_addr_b_ext;
            ow  = s ? bus.bram_wdata_a_ext : bus.bram_wdata_b_ext;
            owe = s ? bus.bram_we_a_ext    : bus.bram_we_b_ext;
            if (oa != 0 || ow != 0 || owe != 0) bad_side++;
            if (swe != 0) begin
                if (wq.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    w = wq.pop_front();
                    chk("wr_addr", sa, w.addr);
                    chk("wr_data", sw, w.data);
                    chk("wr_we", swe, {MW{1'b1}});
                    chk("wr_latency", t, w.cyc + 1);
                end
                if (first_wa < 0) first_wa = int'(sa);
                last_wa = int'(sa);
                writes++;
            end else if (sw != 0) begin
                bad_side++;
            end
            if (bus.done) begin
                dones++;
                if (done_at < 0) done_at = t;
            end
            if (bus.busy !== ((num != 0) && (done_at < 0 || t <= done_at))) bad_busy++;
            if (!d && bus.m_valid) bad_side++;
            if (d && bus.s_ready) bad_side++;
            if (bus.s_valid && bus.s_ready) begin
                w.addr = row(base, sent); w.data = cur_data; w.cyc = t;
                wq.push_back(w);
                if (s) ref_b[w.addr] = cur_data; else ref_a[w.addr] = cur_data;
                sent++;
                cur_data = next_word();
            end
            if (stalled) begin
                chk("stall_valid", bus.m_valid, 1);
                chk("stall_data", bus.m_data, held);
            end
            stalled = 0;
            if (bus.m_valid) begin
                if (bus.m_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_word", 1, 0);
                    end else begin
                        exp_w = exp_q.pop_front();
                        chk("pop_data", bus.m_data, exp_w);
                    end
                    popped++;
                end else begin
                    stalled = 1;
                    held = bus.m_data;
                end
            end
            if (done_at >= 0 && t >= done_at + 2) break;
            step();
            t++;
        end
        chk("done_count", dones, 1);
        if (exp_lat >= 0) chk("done_cycle", done_at, exp_lat);
        chk(d ? "words_popped" : "words_written", d ? popped : writes, num);
        chk(d ? "unload_writes" : "load_pops", d ? writes : popped, 0);
        chk("busy_profile", bad_busy, 0);
        chk("idle_port_quiet", bad_side, 0);
        chk("mem_a_image", mem_diff(1'b0), 0);
        chk("mem_b_image", mem_diff(1'b1), 0);
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b0;
    endtask

    task automatic reset_mid_unload();
        int popped = 0, t = 1, bad = 0;
        bus.start = 1'b1; bus.dir = 1'b1; bus.sel = 1'b0;
        bus.base_addr = '0; bus.num_words = AW'(6);
        bus.m_ready = 1'b1; bus.s_valid = 1'b0;
        step();
        bus.start = 1'b0;
        while (popped < 2 && t < 20) begin
            if (bus.m_valid && bus.m_ready) begin
                chk("abort_pop_data", bus.m_data, ref_a[row(0, popped)]);
                popped++;
            end
            step();
            t++;
        end
        chk("pops_before_reset", popped, 2);
        reset = 1'b1;
        step();
        outputs_zero("abort");
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.done || bus.m_valid || bus.busy || bus.bram_we_a_ext != 0) bad++;
        end
        chk("after_abort_quiet", bad, 0);
        bus.m_ready = 1'b0;
    endtask

    initial begin
        vec_t tbl [8];
        int fa, la, nr, bs;
        bit rd, rs;
        tbl[0] = '{0, 0, 1020, 2, 4, 1020, 0};
        tbl[1] = '{0, 1, 100, 3, 5, 100, 108};
        tbl[2] = '{0, 0, 40, 1, 3, 40, 40};
        tbl[3] = '{1, 0, 1020, 2, 5, -1, -1};
        tbl[4] = '{1, 1, 100, 3, 6, -1, -1};
        tbl[5] = '{1, 0, 0, 1, 4, -1, -1};
        tbl[6] = '{0, 0, 5, 0, 1, -1, -1};
        tbl[7] = '{1, 1, 7, 0, 1, -1, -1};

        bus.start = 1'b0; bus.dir = 1'b0; bus.sel = 1'b0;
        bus.base_addr = '0; bus.num_words = '0;
        bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b0;
        reset = 1'b1;
        repeat (3) step();
        outputs_zero("reset");
        reset = 1'b0;
        step();

        fixed_q = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};
        run_cmd(0, 0, 0, 4, 0, 0, 6, fa, la);
        chk("loadA_first_addr", fa, 0);
        chk("loadA_last_addr", la, 12);
        chk("loadA_row0", mem_a[0], 32'h04030201);
        chk("loadA_row4", mem_a[4], 32'h08070605);
        chk("loadA_row8", mem_a[8], 32'h0C0B0A09);
        chk("loadA_row12", mem_a[12], 32'h100F0E0D);

        for (int i = 0; i < 8; i++) begin
            run_cmd(tbl[i].d, tbl[i].s, tbl[i].base, tbl[i].num, 0, 0, tbl[i].lat, fa, la);
            chk("tbl_first_addr", fa, tbl[i].fa);
            chk("tbl_last_addr", la, tbl[i].la);
        end

        fixed_q = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        run_cmd(0, 1, 16, 4, 0, 0, 6, fa, la);
        run_cmd(1, 1, 16, 4, 2, 0, 14, fa, la);
        chk("bp_rowB28", ref_b[28], 32'h44444444);

        run_cmd(0, 1, 200, 3, 0, 1, 5, fa, la);
        chk("restart_first_addr", fa, 200);
        chk("restart_last_addr", la, 208);

        reset_mid_unload();
        run_cmd(1, 0, 0, 6, 0, 0, 9, fa, la);

        for (int i = 0; i < 25; i++) begin
            rd = 1'($urandom);
            rs = 1'($urandom);
            bs = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1000, 1023)) : int'($urandom_range(0, 63));
            nr = int'($urandom_range(0, 8));
            run_cmd(rd, rs, bs, nr, 1, 0, (nr == 0) ? 1 : -1, fa, la);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
